// File: rtl/tri_solve.sv
// Fixed-point triangular solver T*x = b: forward (UPPER=0) or back (UPPER=1) substitution.
// Optional zero-diagonal abort is enabled by defining TRI_SOLVE_DIAG_CHECK_EN.

package fp_arith_pkg;
   localparam int DATA_WIDTH = 16;
   localparam int FRAC_BITS  = 8;
   localparam logic signed [15:0] FP_ZERO    = 16'sh0000;
   localparam logic signed [15:0] FP_MAX_POS = 16'sh7FFF;
   localparam logic signed [15:0] FP_MIN_NEG = 16'sh8000;
endpackage

module tri_solve
   import fp_arith_pkg::*;
#(
   parameter int N     = 4,
   parameter int UPPER = 0
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     start,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     error,
   input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]      matrix_t,
   input  logic [N-1:0][DATA_WIDTH-1:0]             vector_b,
   output logic [N-1:0][DATA_WIDTH-1:0]             vector_x
);
   localparam int W        = DATA_WIDTH;
   localparam int F        = FRAC_BITS;
   localparam int DIV_BITS = W + F;
   localparam int IW       = (N > 1) ? $clog2(N) : 1;
   localparam int CW       = $clog2(DIV_BITS + 1);
   localparam logic [IW-1:0] FIRST_ROW = (UPPER != 0) ? IW'(N - 1) : IW'(0);
   localparam logic [IW-1:0] LAST_ROW  = (UPPER != 0) ? IW'(0) : IW'(N - 1);
   localparam logic [IW-1:0] ONE_IDX   = IW'(1);
   localparam logic [DIV_BITS-1:0] POS_LIM = DIV_BITS'(2 ** (W - 1) - 1);
   localparam logic [DIV_BITS-1:0] NEG_LIM = DIV_BITS'(2 ** (W - 1));

   typedef enum logic [2:0] {IDLE, ROW_INIT, MAC, RESID, DIV, WRITE, DONE} state_t;

   state_t                state_r, state_s;
   logic [IW-1:0]         row_r, k_r;
   logic [CW-1:0]         cnt_r;
   logic signed [2*W-1:0] acc_r;
   logic [W-2:0]          rem_r;
   logic [DIV_BITS-1:0]   quo_r;
   logic [W-1:0]          dvs_r;
   logic                  neg_r, busy_r, done_r;
   logic [N-1:0][W-1:0]   x_r;

   logic signed [W-1:0]   t_ii_s, t_ik_s, x_k_s, b_i_s, r_s;
   logic signed [2*W-1:0] prod_s;
   logic [W-1:0]          r_mag_s, t_mag_s, rem_sh_s;
   logic                  div_ge_s, has_off_s, last_k_s, last_row_s, div_last_s;

   function automatic logic [W-1:0] abs_mag(input logic signed [W-1:0] v);
      logic [W-1:0] u;
      u = $unsigned(v);
      return v[W-1] ? (~u + W'(1)) : u;
   endfunction

   // Takes acc[2W-1:F]; the residual is the low W bits unless the rest is not sign extension.
   function automatic logic signed [W-1:0] sat_resid(input logic [2*W-F-1:0] a);
      logic [W-F:0] hi;
      hi = a[2*W-F-1:W-1];
      if ((hi == {(W-F+1){1'b0}}) || (hi == {(W-F+1){1'b1}})) return $signed(a[W-1:0]);
      else if (a[2*W-F-1]) return FP_MIN_NEG;
      else return FP_MAX_POS;
   endfunction

   function automatic logic signed [W-1:0] sat_quot(input logic [DIV_BITS-1:0] mag, input logic neg);
      if (neg) begin
         if (mag > NEG_LIM) return FP_MIN_NEG;
         else return $signed(W'(~mag + DIV_BITS'(1)));
      end else begin
         if (mag > POS_LIM) return FP_MAX_POS;
         else return $signed(mag[W-1:0]);
      end
   endfunction

   assign t_ii_s     = $signed(matrix_t[row_r][row_r]);
   assign t_ik_s     = $signed(matrix_t[row_r][k_r]);
   assign x_k_s      = $signed(x_r[k_r]);
   assign b_i_s      = $signed(vector_b[row_r]);
   assign prod_s     = (2*W)'(t_ik_s) * (2*W)'(x_k_s);
   assign r_s        = sat_resid(acc_r[2*W-1:F]);
   assign r_mag_s    = abs_mag(r_s);
   assign t_mag_s    = abs_mag(t_ii_s);
   assign rem_sh_s   = {rem_r, quo_r[DIV_BITS-1]};
   assign div_ge_s   = (rem_sh_s >= dvs_r);
   assign has_off_s  = (row_r != FIRST_ROW);
   assign last_row_s = (row_r == LAST_ROW);
   assign div_last_s = (cnt_r == CW'(DIV_BITS - 1));
   assign last_k_s   = (UPPER != 0) ? ((k_r - ONE_IDX) == row_r) : ((k_r + ONE_IDX) == row_r);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_s;
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:     if (start) state_s = ROW_INIT; else state_s = IDLE;
         ROW_INIT: if (has_off_s) state_s = MAC; else state_s = RESID;
         MAC:      if (last_k_s) state_s = RESID; else state_s = MAC;
`ifdef TRI_SOLVE_DIAG_CHECK_EN
         RESID:    if (t_ii_s == FP_ZERO) state_s = DONE; else state_s = DIV;
`else
         RESID:    state_s = DIV;
`endif
         DIV:      if (div_last_s) state_s = WRITE; else state_s = DIV;
         WRITE:    if (last_row_s) state_s = DONE; else state_s = ROW_INIT;
         DONE:     state_s = IDLE;
         default:  state_s = IDLE;
      endcase
   end

   // Datapath: accumulator, divider, row/column indices and solution vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_r  <= IW'(0);
         k_r    <= IW'(0);
         cnt_r  <= CW'(0);
         acc_r  <= (2*W)'(0);
         rem_r  <= (W-1)'(0);
         quo_r  <= DIV_BITS'(0);
         dvs_r  <= W'(0);
         neg_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         x_r    <= {N{FP_ZERO}};
      end else begin
         done_r <= (state_r == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  busy_r <= 1'b1;
                  row_r  <= FIRST_ROW;
               end
            end
            ROW_INIT: begin
               acc_r <= {{(W-F){b_i_s[W-1]}}, b_i_s, {F{1'b0}}};
               k_r   <= (UPPER != 0) ? IW'(N - 1) : IW'(0);
            end
            MAC: begin
               acc_r <= acc_r - prod_s;
               k_r   <= (UPPER != 0) ? (k_r - ONE_IDX) : (k_r + ONE_IDX);
            end
            RESID: begin
               quo_r <= {r_mag_s, {F{1'b0}}};
               rem_r <= (W-1)'(0);
               dvs_r <= t_mag_s;
               neg_r <= r_s[W-1] ^ t_ii_s[W-1];
               cnt_r <= CW'(0);
            end
            DIV: begin
               // Divisor of zero leaves div_ge_s set every step: all-ones quotient.
               rem_r <= div_ge_s ? (W-1)'(rem_sh_s - dvs_r) : rem_sh_s[W-2:0];
               quo_r <= {quo_r[DIV_BITS-2:0], div_ge_s};
               cnt_r <= cnt_r + CW'(1);
            end
            WRITE: begin
               x_r[row_r] <= sat_quot(quo_r, neg_r);
               row_r      <= (UPPER != 0) ? (row_r - ONE_IDX) : (row_r + ONE_IDX);
            end
            DONE:    busy_r <= 1'b0;
            default: busy_r <= 1'b0;
         endcase
      end
   end

`ifdef TRI_SOLVE_DIAG_CHECK_EN
   logic error_r;

   // Sticky zero-diagonal flag, cleared when a new solve is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    error_r <= 1'b0;
      else if ((state_r == IDLE) && start)           error_r <= 1'b0;
      else if ((state_r == RESID) && (t_ii_s == FP_ZERO)) error_r <= 1'b1;
   end

   assign error = error_r;
`else
   assign error = 1'b0;
`endif

   assign busy     = busy_r;
   assign done     = done_r;
   assign vector_x = x_r;

endmodule

// File: tb/tb_tri_solve.sv
// Directed-vector bench for tri_solve: table of solves on a lower and an upper instance,
// plus hand sequences for zero diagonal, sticky error and asynchronous reset mid-division.
`timescale 1ns/1ps
module tb_tri_solve;
   import fp_arith_pkg::*;
   localparam int N = 4;
   localparam int W = DATA_WIDTH;
   localparam int LAT = 115;

   typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
   typedef logic [N-1:0][W-1:0]        vec_t;
   typedef struct {
      int   id;
      bit   up;
      bit   pulse;
      mat_t t;
      vec_t b;
      vec_t x;
      int   lat;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n, start_lo, start_hi;
   logic busy_lo, done_lo, error_lo, busy_hi, done_hi, error_hi;
   mat_t t_in;
   vec_t b_in, x_lo, x_hi;
   int   checks = 0;
   int   failures = 0;
   int   wr_cyc [N];

   always #5 clk = ~clk;

   tri_solve #(.N(N), .UPPER(0)) dut_lo (
      .clk(clk), .rst_n(rst_n), .start(start_lo), .busy(busy_lo), .done(done_lo),
      .error(error_lo), .matrix_t(t_in), .vector_b(b_in), .vector_x(x_lo));

   tri_solve #(.N(N), .UPPER(1)) dut_hi (
      .clk(clk), .rst_n(rst_n), .start(start_hi), .busy(busy_hi), .done(done_hi),
      .error(error_hi), .matrix_t(t_in), .vector_b(b_in), .vector_x(x_hi));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkvec(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                  input logic [W-1:0] a2, input logic [W-1:0] a3);
      vec_t v;
      v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
      return v;
   endfunction

   function automatic mat_t band(input logic [W-1:0] d, input logic [W-1:0] off, input bit up);
      mat_t m;
      m = '0;
      for (int i = 0; i < N; i++) begin
         m[i][i] = d;
         if (!up && i > 0)     m[i][i-1] = off;
         if (up && i < N - 1)  m[i][i+1] = off;
      end
      return m;
   endfunction

   task automatic run_solve(input bit sel, input bit pulse, output int lat,
                            output bit busy_ok, output logic done_after);
      int   cyc;
      vec_t prev, cur;
      lat = -1;
      busy_ok = 1'b1;
      prev = sel ? x_hi : x_lo;
      for (int i = 0; i < N; i++) wr_cyc[i] = -1;
      @(negedge clk);
      if (sel) start_hi = 1'b1; else start_lo = 1'b1;
      @(negedge clk);
      start_hi = 1'b0;
      start_lo = 1'b0;
      cyc = 0;
      if ((sel ? busy_hi : busy_lo) !== 1'b1) busy_ok = 1'b0;
      while (lat < 0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (pulse && cyc == 40) begin
            if (sel) start_hi = 1'b1; else start_lo = 1'b1;
         end else begin
            start_hi = 1'b0;
            start_lo = 1'b0;
         end
         cur = sel ? x_hi : x_lo;
         for (int i = 0; i < N; i++)
            if (wr_cyc[i] < 0 && cur[i] !== prev[i]) wr_cyc[i] = cyc;
         if ((sel ? done_hi : done_lo) === 1'b1) begin
            lat = cyc;
            if ((sel ? busy_hi : busy_lo) !== 1'b0) busy_ok = 1'b0;
         end else if ((sel ? busy_hi : busy_lo) !== 1'b1) begin
            busy_ok = 1'b0;
         end
      end
      @(negedge clk);
      done_after = sel ? done_hi : done_lo;
   endtask

   initial begin
      rec_t tv [9];
      int   lat;
      bit   bok;
      logic dafter;
      vec_t zx;
      int   zlat;
      logic zerr;

      rst_n = 1'b0;
      start_lo = 1'b0;
      start_hi = 1'b0;
      t_in = '0;
      b_in = '0;

      tv[0] = '{0, 1'b0, 1'b0, band(16'h0100, 16'h0000, 1'b0),
                mkvec(16'h0180, 16'hFE00, 16'h0040, 16'h0300),
                mkvec(16'h0180, 16'hFE00, 16'h0040, 16'h0300), LAT};
      tv[1] = '{1, 1'b0, 1'b1, band(16'h0200, 16'h0100, 1'b0),
                mkvec(16'h0200, 16'h0300, 16'h0300, 16'h0300),
                mkvec(16'h0100, 16'h0100, 16'h0100, 16'h0100), LAT};
      tv[2] = '{2, 1'b1, 1'b0, band(16'h0400, 16'hFF00, 1'b1),
                mkvec(16'h0300, 16'h0300, 16'h0300, 16'h0400),
                mkvec(16'h0100, 16'h0100, 16'h0100, 16'h0100), LAT};
      tv[3] = '{3, 1'b0, 1'b0, band(16'h0100, 16'h0000, 1'b0),
                mkvec(16'hFF00, 16'h0000, 16'h0000, 16'h0000),
                mkvec(16'h0400, 16'h0000, 16'h0000, 16'h0000), LAT};
      tv[3].t[0][0] = 16'hFFC0;
      tv[4] = '{4, 1'b0, 1'b0, band(16'h0100, 16'h0000, 1'b0),
                mkvec(16'h7FFF, 16'h0000, 16'h0000, 16'h0000),
                mkvec(16'h7FFF, 16'h0000, 16'h0000, 16'h0000), LAT};
      tv[4].t[0][0] = 16'h0080;
      tv[5] = '{5, 1'b0, 1'b0, band(16'h0100, 16'h0000, 1'b0),
                mkvec(16'h0100, 16'h0000, 16'h0000, 16'h0000),
                mkvec(16'h0055, 16'h0000, 16'h0000, 16'h0000), LAT};
      tv[5].t[0][0] = 16'h0300;
      tv[6] = '{6, 1'b0, 1'b0, band(16'h0100, 16'h0000, 1'b0),
                mkvec(16'hFF00, 16'h0000, 16'h0000, 16'h0000),
                mkvec(16'hFFAB, 16'h0000, 16'h0000, 16'h0000), LAT};
      tv[6].t[0][0] = 16'h0300;
      tv[7] = '{7, 1'b0, 1'b0, band(16'h0100, 16'h0000, 1'b0),
                mkvec(16'h0100, 16'h0000, 16'h0000, 16'h0000),
                mkvec(16'hFC00, 16'h0000, 16'h0000, 16'h0000), LAT};
      tv[7].t[0][0] = 16'hFFC0;
      tv[8] = '{8, 1'b0, 1'b0, band(16'h0100, 16'h0000, 1'b0),
                mkvec(16'h8000, 16'h0000, 16'h0000, 16'h0000),
                mkvec(16'h8000, 16'h0000, 16'h0000, 16'h0000), LAT};
      tv[8].t[0][0] = 16'h0080;

      repeat (3) @(negedge clk);
      check("reset_busy", {62'd0, busy_lo, busy_hi}, 64'd0);
      check("reset_done", {62'd0, done_lo, done_hi}, 64'd0);
      check("reset_error", {62'd0, error_lo, error_hi}, 64'd0);
      check("reset_x_lo", x_lo, 64'd0);
      check("reset_x_hi", x_hi, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 9; v++) begin
         t_in = tv[v].t;
         b_in = tv[v].b;
         run_solve(tv[v].up, tv[v].pulse, lat, bok, dafter);
         $display("vector %0d solved, latency %0d", tv[v].id, lat);
         check($sformatf("v%0d_x", tv[v].id), tv[v].up ? x_hi : x_lo, tv[v].x);
         check($sformatf("v%0d_latency", tv[v].id), lat, tv[v].lat);
         check($sformatf("v%0d_busy", tv[v].id), {63'd0, bok}, 64'd1);
         check($sformatf("v%0d_done_width", tv[v].id), {63'd0, dafter}, 64'd0);
         check($sformatf("v%0d_error", tv[v].id), {63'd0, tv[v].up ? error_hi : error_lo}, 64'd0);
         if (tv[v].up) begin
            check("back_write_row3", wr_cyc[3], 27);
            check("back_write_row2", wr_cyc[2], 55);
            check("back_write_row1", wr_cyc[1], 84);
            check("back_write_row0", wr_cyc[0], 114);
         end
      end

      // Zero diagonal at T11 after a solve that leaves known values in x.
      t_in = band(16'h0100, 16'h0000, 1'b0);
      b_in = mkvec(16'h0111, 16'h0222, 16'h0333, 16'h0444);
      run_solve(1'b0, 1'b0, lat, bok, dafter);
      check("prefill_x", x_lo, mkvec(16'h0111, 16'h0222, 16'h0333, 16'h0444));
      t_in[1][1] = 16'h0000;
      b_in = mkvec(16'h0100, 16'h0100, 16'h0100, 16'h0100);
`ifdef TRI_SOLVE_DIAG_CHECK_EN
      zx   = mkvec(16'h0100, 16'h0222, 16'h0333, 16'h0444);
      zlat = 31;
      zerr = 1'b1;
`else
      zx   = mkvec(16'h0100, 16'h7FFF, 16'h0100, 16'h0100);
      zlat = LAT;
      zerr = 1'b0;
`endif
      run_solve(1'b0, 1'b0, lat, bok, dafter);
      check("zdiag_x", x_lo, zx);
      check("zdiag_latency", lat, zlat);
      check("zdiag_error", {63'd0, error_lo}, {63'd0, zerr});
      check("zdiag_done_width", {63'd0, dafter}, 64'd0);
      repeat (3) @(negedge clk);
      check("zdiag_error_sticky", {63'd0, error_lo}, {63'd0, zerr});
      t_in = band(16'h0100, 16'h0000, 1'b0);
      run_solve(1'b0, 1'b0, lat, bok, dafter);
      check("clean_after_error_x", x_lo, mkvec(16'h0100, 16'h0100, 16'h0100, 16'h0100));
      check("clean_after_error_err", {63'd0, error_lo}, 64'd0);

      // Asynchronous reset while row 0 is dividing.
      b_in = mkvec(16'h0123, 16'hFF80, 16'h0200, 16'h0010);
      @(negedge clk);
      start_lo = 1'b1;
      @(negedge clk);
      start_lo = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_reset_busy", {63'd0, busy_lo}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", {63'd0, busy_lo}, 64'd0);
      check("midrst_done", {63'd0, done_lo}, 64'd0);
      check("midrst_error", {63'd0, error_lo}, 64'd0);
      check("midrst_x_lo", x_lo, 64'd0);
      check("midrst_x_hi", x_hi, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_solve(1'b0, 1'b0, lat, bok, dafter);
      check("post_reset_x", x_lo, mkvec(16'h0123, 16'hFF80, 16'h0200, 16'h0010));
      check("post_reset_latency", lat, LAT);
      check("post_reset_busy", {63'd0, bok}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tri_solve.md
# tri_solve

Fixed-point triangular solver: computes vector x such that T·x = b, where T is an N×N lower- or upper-triangular matrix. It uses sequential forward or back substitution with one shared MAC and an iterative restoring divider. It is the inverse companion of the EKF matrix multipliers and handles the Kalman-gain / innovation-covariance solve steps after Cholesky factorisation. All arithmetic uses `fp_arith_pkg` (`DATA_WIDTH`, `FRAC_BITS`, `FP_ZERO`, `FP_MAX_POS`, `FP_MIN_NEG`).

## Interface
- `N`, 4, matrix order / vector length (≥2)
- `UPPER`, 0, 0 = lower-triangular (forward substitution), 1 = upper-triangular (back substitution)
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `start`  in  1  begin solve; sampled only in IDLE
- `busy`  out  1  high from the cycle after start is accepted until done
- `done`  out  1  one-cycle completion pulse
- `error`  out  1  zero diagonal detected; sticky until next accepted start
- `matrix_t`  in  N×N×DATA_WIDTH signed  triangular matrix; entries outside the triangle are ignored
- `vector_b`  in  N×DATA_WIDTH signed  right-hand side
- `vector_x`  out  N×DATA_WIDTH signed  solution

## Operation
- `matrix_t` and `vector_b` must be held stable while busy; they are read combinationally and not latched.
- Row order:
  - UPPER=0: i = 0..N-1, with MAC over k < i.
  - UPPER=1: i = N-1..0, with MAC over k > i.
- FSM states: IDLE, ROW_INIT, MAC, RESID, DIV, WRITE, DONE.
- IDLE + start → ROW_INIT. busy←1, error←0, row index set to the first row.
- ROW_INIT: acc (2·DATA_WIDTH signed) ← b[i] << FRAC_BITS. k set to the first off-diagonal column. Go to MAC, or straight to RESID if the row has no off-diagonal terms.
- MAC: acc ← acc − T[i][k]·x[k], one term per cycle. x[k] comes from `vector_x` as already written in this solve.
- RESID: r = acc[FRAC_BITS+DATA_WIDTH-1:FRAC_BITS], saturated to FP_MAX_POS / FP_MIN_NEG if the upper bits are not sign-extension. Latch the divider operands |r| << FRAC_BITS and |T[i][i]|. Go to DIV.
- DIV: restoring division, one quotient bit per cycle for DIV_BITS = DATA_WIDTH+FRAC_BITS cycles.
- WRITE:
  - q = sign(r) xor sign(T[i][i]) applied to the quotient magnitude, truncated toward zero, saturated to FP_MAX_POS / FP_MIN_NEG.
  - vector_x[i] ← q.
  - Go to ROW_INIT for the next row, or to DONE after the last row.
- DONE: done←1, busy←0 → IDLE. done is cleared in IDLE.
- Elements of `vector_x` not yet rewritten keep their prior values and are never read before being rewritten.
- start while busy is ignored.
- Reset mid-solve returns to IDLE with all outputs at their reset values.

## Timing
- Reset values: busy=0, done=0, error=0, vector_x all FP_ZERO, state IDLE.
- Per-row cycle count for row with m off-diagonal terms: 1 (ROW_INIT) + m (MAC) + 1 (RESID) + DIV_BITS + 1 (WRITE).
- Total latency: N·(DIV_BITS+3) + N(N−1)/2 + 1 cycles from the start-accepting edge to the edge asserting done.
- vector_x[i] is valid from the WRITE edge of row i. The full vector is valid when done is high and stays held until the next accepted start rewrites it.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted in the following IDLE cycle.

## Configuration
- Macro `TRI_SOLVE_DIAG_CHECK_EN`.
- Defined:
  - In RESID, T[i][i]==0 sets error=1 and jumps to DONE.
  - done still pulses; remaining elements are not rewritten.
  - Latency is shortened accordingly.
- Undefined:
  - No check is made, and `error` is tied 0.
  - Division by zero yields an all-ones magnitude, which saturates to FP_MAX_POS (r ≥ 0) or FP_MIN_NEG (r < 0).

## Test plan
- Identity: N=4, UPPER=0, T=I, b=[1.5,−2,0.25,3] → x=b exactly, done one cycle at the computed latency, busy high throughout.
- Forward: N=4, UPPER=0, diag 2.0, sub-diag 1.0, b=[2,3,3,3] → x=[1,1,1,1], error=0.
- Back: N=4, UPPER=1, diag 4.0, super-diag −1.0, b=[3,3,3,4] → x=[1,1,1,1], rows written in order 3→0.
- Sign and saturation:
  - T00=−0.25, b0=−1 → x0=4.0.
  - T00=0.5, b0=FP_MAX_POS → x0=FP_MAX_POS.
  - T00=3.0, b0=1.0 → x0=truncated 1/3, last bit toward zero.
- Zero diagonal, T11=0:
  - With macro: error=1, done pulse after row 1's RESID, x[2..3] unchanged.
  - Without macro: x1 saturates, error=0.
- Control: start pulsed during busy → no restart, latency unchanged. rst_n low mid-DIV → all outputs at reset values immediately; a new start then solves correctly.
